// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared scan state encoding and active-low segment constants.
package seg_scan_ctrl_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_ON} state_t;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [15:0][6:0] GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// hex_seg_decode: combinational hex nibble to active-low {g,f,e,d,c,b,a} glyph.
module hex_seg_decode
   import seg_scan_ctrl_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   assign seg = GLYPH[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scanner with tear-free updates,
// inter-digit guard blanking and optional leading-zero suppression.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000,
   parameter int GUARD      = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    upd_valid,
   input  logic [4*NUM_DIGITS-1:0] upd_data,
   input  logic [NUM_DIGITS-1:0]   upd_dp,
   output logic                    upd_ready,
   input  logic                    lz_blank,
   output logic [NUM_DIGITS-1:0]   digit_an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW = $clog2((DIV > GUARD ? DIV : GUARD) + 1);
   state_t                  state;
   logic [IW-1:0]           idx;
   logic [PW-1:0]           presc;
   logic [4*NUM_DIGITS-1:0] disp, pend;
   logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
   logic                    pend_full;
   logic [NUM_DIGITS:0]     zero_hi;
   logic [6:0]              glyph;
   logic                    on, last_on, last_digit, xfer, swap, lz_hide;
   assign on         = state == ST_ON;
   assign last_on    = on && presc == PW'(DIV - 1);
   assign last_digit = idx == IW'(NUM_DIGITS - 1);
   assign frame_done = en & last_on & last_digit;
   assign upd_ready  = ~pend_full;
   assign xfer       = upd_valid & ~pend_full;
   assign swap       = pend_full & ((state == ST_IDLE) | frame_done);
   // zero_hi[i]: nibble i and every more-significant nibble are zero
   always_comb begin
      zero_hi = '0;
      zero_hi[NUM_DIGITS] = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--)
         zero_hi[i] = zero_hi[i+1] & (disp[4*i +: 4] == 4'd0);
   end
   assign lz_hide = lz_blank && idx != '0 && zero_hi[idx];
   hex_seg_decode u_dec (.hex(disp[{idx, 2'b00} +: 4]), .seg(glyph));
   assign digit_an = on ? ~(NUM_DIGITS'(1) << idx) : '1;
   assign seg      = on && !lz_hide ? glyph : SEG_BLANK;
   assign dp       = on ? ~disp_dp[idx] : 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         presc     <= '0;
         disp      <= '0;
         disp_dp   <= '0;
         pend      <= '0;
         pend_dp   <= '0;
         pend_full <= 1'b0;
      end else begin
         if (xfer) begin
            pend    <= upd_data;
            pend_dp <= upd_dp;
         end
         if (swap) begin
            disp    <= pend;
            disp_dp <= pend_dp;
         end
         pend_full <= xfer | (pend_full & ~swap);
         if (!en) begin
            state <= ST_IDLE;
            idx   <= '0;
            presc <= '0;
         end else case (state)
            ST_IDLE: begin
               idx   <= '0;
               presc <= '0;
               state <= GUARD == 0 ? ST_ON : ST_GUARD;
            end
            ST_GUARD:
               if (presc == PW'(GUARD - 1)) begin
                  presc <= '0;
                  state <= ST_ON;
               end else presc <= presc + PW'(1);
            ST_ON:
               if (last_on) begin
                  presc <= '0;
                  idx   <= last_digit ? '0 : idx + IW'(1);
                  state <= GUARD == 0 ? ST_ON : ST_GUARD;
               end else presc <= presc + PW'(1);
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed frame/handshake/blanking scenarios plus random traffic,
// checked every cycle against a frame-position model of the scanner.
module tb_seg_scan_ctrl;
   localparam int N = 4, DIV = 4, GUARD = 1;
   localparam int SL = DIV + GUARD, FL = N * SL;
   logic        clk = 0, rst_n = 0, en = 0, upd_valid = 0, lz_blank = 0;
   logic [15:0] upd_data = '0;
   logic [3:0]  upd_dp = '0;
   logic        upd_ready, dp, frame_done;
   logic [3:0]  digit_an;
   logic [6:0]  seg;
   int          errors = 0, checks = 0;
   logic [6:0]  gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .GUARD(GUARD)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .upd_valid(upd_valid), .upd_data(upd_data),
      .upd_dp(upd_dp), .upd_ready(upd_ready), .lz_blank(lz_blank), .digit_an(digit_an),
      .seg(seg), .dp(dp), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask
   // Model: m_t counts cycles since the scan left idle (-1 = idle); everything
   // visible follows from the position inside the frame.
   int          m_t = -1;
   logic [15:0] m_disp = '0, m_pend = '0;
   logic [3:0]  m_dp = '0, m_pdp = '0;
   logic        m_full = 0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_t = -1; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_full = 0;
      end else begin : step
         logic fd, xf, sw;
         fd = en && m_t >= 0 && (m_t % FL) == FL - 1;
         xf = upd_valid && !m_full;
         sw = m_full && (m_t < 0 || fd);
         if (sw) begin m_disp = m_pend; m_dp = m_pdp; end
         if (xf) begin m_pend = upd_data; m_pdp = upd_dp; end
         m_full = xf || (m_full && !sw);
         m_t = en ? m_t + 1 : -1;
      end
   always @(negedge clk) begin : cmp
      logic [3:0] e_an; logic [6:0] e_seg; logic e_dp, e_fd; int ph, d;
      logic [15:0] hi;
      e_an = '1; e_seg = 7'h7F; e_dp = 1; e_fd = 0;
      if (m_t >= 0) begin
         ph = m_t % FL;
         d = ph / SL;
         hi = m_disp >> (4 * d);
         if (ph % SL >= GUARD) begin
            e_an = ~(4'(1) << d);
            e_seg = (lz_blank && d > 0 && hi == 0) ? 7'h7F : gl[4'(hi)];
            e_dp = ~m_dp[d];
         end
         e_fd = en && ph == FL - 1;
      end
      chk("m_an", digit_an, e_an);
      chk("m_seg", seg, e_seg);
      chk("m_dp", dp, e_dp);
      chk("m_fd", frame_done, e_fd);
      chk("m_rdy", upd_ready, !m_full);
   end
   task automatic cyc();
      @(posedge clk); #1;
   endtask
   task automatic load(input logic [15:0] v, input logic [3:0] p);
      upd_data = v; upd_dp = p; upd_valid = 1; cyc();
      upd_valid = 0; cyc(); cyc();
   endtask
   initial begin
      repeat (3) cyc();
      chk("rst_an", digit_an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1);
      chk("rst_rdy", upd_ready, 1);
      rst_n = 1;
      repeat (4) begin cyc(); chk("idle_fd", frame_done, 0); chk("idle_an", digit_an, 4'hF); end
      load(16'h1234, 4'b0000);
      en = 1;
      for (int c = 1; c <= 100; c++) begin
         cyc();
         case (c)
            1:  chk("g1_an", digit_an, 4'hF);
            2:  begin chk("d0_an", digit_an, 4'hE); chk("d0_seg", seg, 7'h19); end
            5:  chk("d0_last", digit_an, 4'hE);
            6:  chk("g6_an", digit_an, 4'hF);
            7:  begin chk("d1_an", digit_an, 4'hD); chk("d1_seg", seg, 7'h30); end
            19: chk("fd19", frame_done, 0);
            20: begin chk("fd20", frame_done, 1); chk("d3_seg", seg, 7'h79); end
            21: begin chk("fd21", frame_done, 0); chk("g21_an", digit_an, 4'hF); end
            23: begin upd_data = 16'hABCD; upd_valid = 1; end
            24: begin chk("rdy24", upd_ready, 0); upd_valid = 0; end
            32: chk("tear_d2", seg, 7'h24);
            40: begin chk("fd40", frame_done, 1); chk("rdy40", upd_ready, 0); end
            41: chk("rdy41", upd_ready, 1);
            42: chk("new_d0", seg, 7'h21);
            43: begin upd_data = 16'h5678; upd_valid = 1; end
            44: begin chk("rdy44", upd_ready, 0); upd_data = 16'hEEEE; end
            45: upd_data = 16'h9ABC;
            61: chk("rdy61", upd_ready, 1);
            62: begin chk("rdy62", upd_ready, 0); chk("b2b_d0", seg, 7'h00); upd_valid = 0; end
            82: chk("b2b2_d0", seg, 7'h46);
            default: ;
         endcase
      end
      en = 0;
      repeat (3) cyc();
      load(16'h0050, 4'b0010);
      lz_blank = 1;
      en = 1;
      for (int c = 1; c <= 64; c++) begin
         cyc();
         case (c)
            2:  begin chk("lz_d0", seg, 7'h40); chk("lz_dp0", dp, 1); end
            7:  begin chk("lz_d1", seg, 7'h12); chk("lz_dp1", dp, 0); end
            12: begin chk("lz_an2", digit_an, 4'hB); chk("lz_d2", seg, 7'h7F); end
            17: begin chk("lz_an3", digit_an, 4'h7); chk("lz_d3", seg, 7'h7F); end
            21: lz_blank = 0;
            32: chk("nolz_d2", seg, 7'h40);
            37: chk("nolz_d3", seg, 7'h40);
            53: begin chk("ab_an", digit_an, 4'hB); en = 0; end
            54: begin chk("ab_blank", digit_an, 4'hF); chk("ab_seg", seg, 7'h7F); chk("ab_fd", frame_done, 0); en = 1; end
            55: chk("re_g", digit_an, 4'hF);
            56: begin chk("re_d0", digit_an, 4'hE); chk("re_seg", seg, 7'h40); end
            58: begin upd_data = 16'h7777; upd_valid = 1; end
            59: begin chk("rdy59", upd_ready, 0); upd_valid = 0; end
            60: chk("old_fd", frame_done, 0);
            62: begin
               chk("pre_rst_an", digit_an, 4'hD);
               rst_n = 0; #1;
               chk("ar_an", digit_an, 4'hF);
               chk("ar_seg", seg, 7'h7F);
               chk("ar_dp", dp, 1);
               chk("ar_rdy", upd_ready, 1);
            end
            63: begin rst_n = 1; en = 0; end
            default: ;
         endcase
      end
      repeat (3) cyc();
      en = 1;
      for (int c = 1; c <= 7; c++) begin
         cyc();
         if (c == 2) chk("clr_d0", seg, 7'h40);
         if (c == 7) begin chk("clr_d1", seg, 7'h40); chk("clr_rdy", upd_ready, 1); end
      end
      for (int i = 0; i < 3000; i++) begin
         cyc();
         en = $urandom_range(0, 49) != 0;
         upd_valid = $urandom_range(0, 7) == 0;
         upd_data = 16'($urandom) >> (4 * $urandom_range(0, 3));
         upd_dp = 4'($urandom);
         if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
